// File: rtl/bytepad_strip.sv
// Receive-side bytepad stripper: checks the left_encode(W) header, forwards the
// len payload bytes with zero latency and consumes and checks the zero padding.
module bytepad_strip #(
    parameter int W     = 8,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err_hdr,
    output logic             err_pad
);
    localparam int POS_W = $clog2(W);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(W - 1);
    localparam logic [7:0]       W_BYTE   = 8'(W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_PAD,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [POS_W-1:0] pos_reg;
    logic [POS_W-1:0] pos_next;
    logic [LEN_W-1:0] cnt_reg;
    logic             err_hdr_reg;
    logic             err_pad_reg;
    logic             accept;
    logic             cnt_is_one;
    logic             block_end;

    assign cnt_is_one = (cnt_reg == LEN_W'(1));
    assign pos_next   = (pos_reg == POS_LAST) ? '0 : pos_reg + POS_W'(1);
    assign block_end  = (pos_next == '0);
    assign accept     = in_valid && in_ready;

    // DATA is a combinational pass-through so the payload sees no extra latency.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 8'h00;
        case (state_reg)
            S_HDR0, S_HDR1, S_PAD: in_ready = 1'b1;
            S_DATA: begin
                in_ready  = out_ready;
                out_valid = in_valid;
                out_last  = cnt_is_one;
                out_data  = in_data;
            end
            default: ;
        endcase
    end

    assign busy    = (state_reg != S_IDLE);
    assign done    = (state_reg == S_DONE);
    assign err_hdr = err_hdr_reg;
    assign err_pad = err_pad_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            pos_reg     <= '0;
            cnt_reg     <= '0;
            err_hdr_reg <= 1'b0;
            err_pad_reg <= 1'b0;
        end else begin
            if (accept) begin
                pos_reg <= pos_next;
            end
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg   <= S_HDR0;
                        cnt_reg     <= len;
                        pos_reg     <= '0;
                        err_hdr_reg <= 1'b0;
                        err_pad_reg <= 1'b0;
                    end
                end
                S_HDR0: begin
                    if (accept) begin
                        if (in_data != 8'h01) begin
                            err_hdr_reg <= 1'b1;
                            state_reg   <= S_DONE;
                        end else begin
                            state_reg <= S_HDR1;
                        end
                    end
                end
                S_HDR1: begin
                    if (accept) begin
                        if (in_data != W_BYTE) begin
                            err_hdr_reg <= 1'b1;
                            state_reg   <= S_DONE;
                        end else if (cnt_reg == '0) begin
                            state_reg <= block_end ? S_DONE : S_PAD;
                        end else begin
                            state_reg <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        cnt_reg <= cnt_reg - LEN_W'(1);
                        if (cnt_is_one) begin
                            state_reg <= block_end ? S_DONE : S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    if (accept) begin
                        if (in_data != 8'h00) begin
                            err_pad_reg <= 1'b1;
                        end
                        if (block_end) begin
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/bytepad_strip.md
Name: bytepad_strip

Overview:
- Receive-side counterpart of the KMAC bytepad stage.
- Consumes a byte stream framed as bytepad(X, W) = left_encode(W) || X || 0x00… up to a multiple of W bytes.
- Checks the left_encode header, forwards exactly the `len` payload bytes of X downstream, and consumes and checks the zero padding.
- Sits between a byte-stream source (e.g. a KMAC key/customisation reader) and the consumer of the raw string.

Parameters:
- W, default 8: block size in bytes. Legal range 2..255, so left_encode(W) is always the two bytes 0x01, W.
- LEN_W, default 16: width of the payload length field.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin one frame; sampled only in IDLE.
- len, input, LEN_W: payload length in bytes; latched on accepted start.
- in_data, input, 8: incoming padded byte.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: byte accepted when in_valid && in_ready.
- out_data, output, 8: payload byte.
- out_valid, output, 1: out_data valid.
- out_ready, input, 1: downstream accepts.
- out_last, output, 1: qualifies the final payload byte.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse at end of frame.
- err_hdr, output, 1: sticky, header mismatch.
- err_pad, output, 1: sticky, nonzero padding byte seen.

Behaviour:
- Reset: state IDLE. pos=0, cnt=0. in_ready, out_valid, out_last, busy, done, err_hdr, err_pad all 0.
- States: IDLE, HDR0, HDR1, DATA, PAD, DONE.
- Counters:
  - pos, $clog2(W) bits: block position. Cleared on start; increments on every accepted input byte (header, data and pad alike); wraps W-1 → 0.
  - cnt, LEN_W bits: remaining payload bytes. Loaded with len on start.
  - pos_next denotes the value of pos after the current accepted byte.
- IDLE:
  - start=1 → HDR0. Latch len, clear pos, err_hdr and err_pad.
  - start is ignored in all other states.
- HDR0:
  - in_ready=1.
  - On accept: byte ≠ 0x01 → set err_hdr, go to DONE. Otherwise → HDR1.
- HDR1:
  - in_ready=1.
  - On accept: byte ≠ W → set err_hdr, go to DONE.
  - Else if cnt==0 → DONE if pos_next==0, otherwise PAD.
  - Else → DATA.
- DATA (combinational pass-through, zero latency):
  - out_data=in_data, out_valid=in_valid, in_ready=out_ready, out_last=(cnt==1).
  - On handshake: cnt decrements.
  - On the handshake with out_last: → DONE if pos_next==0, otherwise PAD.
- PAD:
  - in_ready=1, out_valid=0.
  - On accept: byte ≠ 0x00 sets err_pad; processing continues.
  - When pos_next==0 → DONE.
- DONE:
  - done=1 for exactly one cycle, in_ready=0, then → IDLE.
  - err_hdr and err_pad hold until the next accepted start.
- Header error aborts the frame: no payload is output, and remaining frame bytes are left unconsumed (upstream must flush).
- Outside DATA, out_valid and out_last are 0. Outside HDR0, HDR1, DATA and PAD, in_ready is 0.
- Bytes consumed per good frame: 2 + len + ((W − (2+len) mod W) mod W).
- Backpressure: in_valid=0 or out_ready=0 stalls the current state; no counter changes; no byte is lost or duplicated.
- Length range: len up to 2^LEN_W − 1 is supported; pos wraps as often as needed.
- Reset mid-frame: immediate return to IDLE with the reset values above; any partial frame is discarded.

Test Plan:
- Short payload (W=8, len=3): feed 01 08 AA BB CC 00 00 00 → out AA BB CC, out_last on CC; 8 bytes consumed; done pulses the cycle after the last pad byte; no errors.
- Exact fit (W=8, len=6): feed 01 08 11 22 33 44 55 66 → 6 output bytes, out_last on 66; PAD skipped; done the next cycle; 8 bytes consumed.
- Empty payload (W=8, len=0): feed 01 08 00×6 → no out_valid; done after the 8th byte. With W=2 and len=0: done right after 01 02.
- Bad header (W=8, len=3): feed 01 10 → err_hdr=1 and done after the 2nd byte; in_ready=0 afterwards; no output. Next start clears err_hdr.
- Bad padding (W=8, len=3): feed 01 08 AA BB CC 00 5A 00 → payload AA BB CC output; err_pad=1; all 8 bytes consumed; done pulses.
- Backpressure and reset (len=3): hold out_ready=0 for 3 cycles mid-DATA → in_ready=0 and the byte stays pending, output sequence intact. Assert rst_n=0 mid-DATA → busy=0 and all outputs 0; a new frame then decodes correctly.
